// File: rtl/tpu_tile_scheduler_if.sv
// Control bundle between the tile scheduler, the global buffers and the 4x4 PE array.
// master = scheduler side, slave = datapath/top-level side.
interface tpu_tile_scheduler_if #(
    parameter int ADDR_W = 8,
    parameter int DIM_W  = 4
);
    logic              start;
    logic [DIM_W-1:0]  m;
    logic [DIM_W-1:0]  n;
    logic [DIM_W-1:0]  k;
    logic              done;
    logic [ADDR_W-1:0] index_a;
    logic [ADDR_W-1:0] index_b;
    logic              ld_en;
    logic [DIM_W-1:0]  ld_k;
    logic              arr_start;
    logic              arr_done;
    logic [1:0]        res_sel;
    logic [3:0]        col_mask;
    logic              wr_en_out;
    logic [ADDR_W-1:0] index_out;

    modport master (
        input  start, m, n, k, arr_done,
        output done, index_a, index_b, ld_en, ld_k, arr_start,
               res_sel, col_mask, wr_en_out, index_out
    );

    modport slave (
        output start, m, n, k, arr_done,
        input  done, index_a, index_b, ld_en, ld_k, arr_start,
               res_sel, col_mask, wr_en_out, index_out
    );
endinterface

// File: rtl/tpu_tile_scheduler.sv
// Sequences one MxK * KxN GEMM on the 4x4 systolic array, tile by tile (row tile outer).
// Optional TPU_SCHED_PERF_EN adds a saturating start-to-done cycle counter (perf_cycles).
module tpu_tile_scheduler #(
    parameter int ADDR_W = 8,
    parameter int DIM_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    tpu_tile_scheduler_if.master bus
`ifdef TPU_SCHED_PERF_EN
    ,
    output logic [15:0]          perf_cycles
`endif
);
    localparam int TW = DIM_W - 2;  // tile counter width (4-wide tiles)
    localparam int CW = DIM_W + 2;  // covers k + RD_LAT - 1

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_COMPUTE, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0] m_r, n_r, k_r;
    logic [TW-1:0]    rt, ct;
    logic [TW-1:0]    mt_last, nt_last;
    logic [1:0]       row_last;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    fetch_last;
    logic             accept, dims_zero, iss;

    logic [RD_LAT:1]            vld_pipe;
    logic [RD_LAT:1][DIM_W-1:0] ld_k_pipe;

    assign accept     = bus.start && (state == S_IDLE || state == S_DONE);
    assign dims_zero  = (bus.m == '0) || (bus.n == '0) || (bus.k == '0);
    assign mt_last    = m_r[DIM_W-1:2] - TW'(m_r[1:0] == 2'b00);
    assign nt_last    = n_r[DIM_W-1:2] - TW'(n_r[1:0] == 2'b00);
    // Last row tile may be partial: R-1 = (m-1) mod 4.
    assign row_last   = (rt == mt_last) ? (m_r[1:0] - 2'd1) : 2'd3;
    assign fetch_last = {2'b00, k_r} + CW'(RD_LAT - 1);
    assign iss        = (state == S_FETCH) && (cnt < {2'b00, k_r});

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_nxt = dims_zero ? S_DONE : S_FETCH;
            S_FETCH:        if (cnt == fetch_last) state_nxt = S_COMPUTE;
            S_COMPUTE:      if (bus.arr_done) state_nxt = S_WRITE;
            S_WRITE:        if (cnt[1:0] == row_last) state_nxt = S_NEXT;
            S_NEXT:         state_nxt = (rt == mt_last && ct == nt_last) ? S_DONE : S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // cnt restarts on every state change; in COMPUTE it parks at 1 so arr_start fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r <= '0;
            n_r <= '0;
            k_r <= '0;
            rt  <= '0;
            ct  <= '0;
            cnt <= '0;
        end else begin
            if (accept) begin
                m_r <= bus.m;
                n_r <= bus.n;
                k_r <= bus.k;
                rt  <= '0;
                ct  <= '0;
            end else if (state == S_NEXT) begin
                if (ct == nt_last) begin
                    ct <= '0;
                    rt <= rt + 1'b1;
                end else begin
                    ct <= ct + 1'b1;
                end
            end
            if (state_nxt != state)                   cnt <= '0;
            else if (state != S_COMPUTE || cnt == '0) cnt <= cnt + 1'b1;
        end
    end

    // Load strobe tracks the GBUFF read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            ld_k_pipe <= '0;
        end else begin
            vld_pipe[1]  <= iss;
            ld_k_pipe[1] <= cnt[DIM_W-1:0];
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                ld_k_pipe[i] <= ld_k_pipe[i-1];
            end
        end
    end

    always_comb begin
        bus.done      = (state == S_DONE);
        bus.arr_start = (state == S_COMPUTE) && (cnt == '0);
        bus.ld_en     = vld_pipe[RD_LAT];
        bus.ld_k      = ld_k_pipe[RD_LAT];
        bus.index_a   = '0;
        bus.index_b   = '0;
        bus.wr_en_out = 1'b0;
        bus.res_sel   = 2'd0;
        bus.index_out = '0;
        bus.col_mask  = 4'b0000;
        if (iss) begin
            bus.index_a = ADDR_W'(rt) * ADDR_W'(k_r) + ADDR_W'(cnt);
            bus.index_b = ADDR_W'(ct) * ADDR_W'(k_r) + ADDR_W'(cnt);
        end
        if (state == S_WRITE) begin
            bus.wr_en_out = 1'b1;
            bus.res_sel   = cnt[1:0];
            bus.index_out = ADDR_W'(ct) * ADDR_W'(m_r) + ADDR_W'({rt, 2'b00}) + ADDR_W'(cnt[1:0]);
        end
        if (state == S_FETCH || state == S_COMPUTE || state == S_WRITE) begin
            for (int j = 0; j < 4; j++)
                bus.col_mask[j] = ({1'b0, ct, 2'b00} + (DIM_W+1)'(j)) < {1'b0, n_r};
        end
    end

`ifdef TPU_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_cycles <= '0;
        else if (accept)
            perf_cycles <= '0;
        else if (state != S_IDLE && state != S_DONE && perf_cycles != 16'hFFFF)
            perf_cycles <= perf_cycles + 16'd1;
    end
`endif
endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed bench for tpu_tile_scheduler: array model answers arr_start after 5 cycles,
// a monitor logs load/write traffic, and each scenario task checks the logs.
module tb_tpu_tile_scheduler;
    localparam int ADDR_W = 8;
    localparam int DIM_W  = 4;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tpu_tile_scheduler_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();
`ifdef TPU_SCHED_PERF_EN
    logic [15:0] perf_cycles;
`endif

    tpu_tile_scheduler #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef TPU_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    int   ld_log[$];
    int   wr_log[$];
    int   n_arr_start = 0;
    int   arr_cnt = 0;
    logic arr_auto = 1'b0;
    logic arr_inj = 1'b0;
    logic [ADDR_W-1:0] prev_a = '0;
    logic [ADDR_W-1:0] prev_b = '0;

    assign bus.arr_done = arr_auto | arr_inj;

    // Array model + traffic monitor; ld entries pair the capture with indices one cycle earlier.
    always @(negedge clk) begin
        if (arr_cnt > 0) begin
            arr_cnt  = arr_cnt - 1;
            arr_auto = (arr_cnt == 0);
        end else begin
            arr_auto = 1'b0;
        end
        if (bus.arr_start === 1'b1) begin
            n_arr_start++;
            arr_cnt = 5;
        end
        if (bus.ld_en === 1'b1)
            ld_log.push_back((int'(prev_a) << 16) | (int'(prev_b) << 8) | int'(bus.ld_k));
        prev_a = bus.index_a;
        prev_b = bus.index_b;
        if (bus.wr_en_out === 1'b1)
            wr_log.push_back((int'(bus.index_out) << 8) | (int'(bus.res_sel) << 4) | int'(bus.col_mask));
    end

    task automatic run_gemm(input int mm, input int nn, input int kk,
                            input int inj_done, input int inj_start,
                            output int cyc, output bit timeout);
        @(negedge clk);
        bus.m = DIM_W'(mm);
        bus.n = DIM_W'(nn);
        bus.k = DIM_W'(kk);
        bus.start = 1'b1;
        ld_log.delete();
        wr_log.delete();
        n_arr_start = 0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 2000) begin
            arr_inj   = (cyc == inj_done);
            bus.start = (cyc == inj_start);
            @(negedge clk);
            cyc++;
        end
        arr_inj   = 1'b0;
        bus.start = 1'b0;
        timeout   = (bus.done !== 1'b1);
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        outs = {bus.done, bus.ld_en, bus.arr_start, bus.wr_en_out, bus.index_a, bus.index_b,
                bus.ld_k, bus.res_sel, bus.col_mask, bus.index_out};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
`ifdef TPU_SCHED_PERF_EN
        checks++;
        if (perf_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf got %0d want 0", perf_cycles);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    // m=n=k=4: one tile; 4+1 fetch, 6 compute, 4 write, 1 next = 16 cycles.
    task automatic test_single_tile(input string nm, input int inj_done, input int inj_start);
        int cyc;
        bit to;
        run_gemm(4, 4, 4, inj_done, inj_start, cyc, to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_timeout got no done want done", nm); end
        checks++;
        if (cyc != 16) begin errors++; $display("FAIL %s_cycles got %0d want 16", nm, cyc); end
        checks++;
        if (ld_log.size() != 4) begin errors++; $display("FAIL %s_ld_count got %0d want 4", nm, ld_log.size()); end
        for (int i = 0; i < 4 && i < ld_log.size(); i++) begin
            checks++;
            if (ld_log[i] != ((i << 16) | (i << 8) | i)) begin
                errors++;
                $display("FAIL %s_ld%0d got %h want %h", nm, i, ld_log[i], (i << 16) | (i << 8) | i);
            end
        end
        checks++;
        if (wr_log.size() != 4) begin errors++; $display("FAIL %s_wr_count got %0d want 4", nm, wr_log.size()); end
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i] != ((i << 8) | (i << 4) | 15)) begin
                errors++;
                $display("FAIL %s_wr%0d got %h want %h", nm, i, wr_log[i], (i << 8) | (i << 4) | 15);
            end
        end
        checks++;
        if (n_arr_start != 1) begin errors++; $display("FAIL %s_arr_start got %0d want 1", nm, n_arr_start); end
`ifdef TPU_SCHED_PERF_EN
        checks++;
        if (perf_cycles !== 16'd16) begin errors++; $display("FAIL %s_perf got %0d want 16", nm, perf_cycles); end
`endif
    endtask

    // m=5,n=3,k=2: tiles rt0 (4 rows) and rt1 (1 row); 14 + 11 cycles.
    task automatic test_uneven();
        int cyc;
        bit to;
        int exp_ld[4] = '{32'h000000, 32'h010101, 32'h020000, 32'h030101};
        int exp_wr[5] = '{32'h007, 32'h117, 32'h227, 32'h337, 32'h407};
        run_gemm(5, 3, 2, -1, -1, cyc, to);
        checks++;
        if (to || cyc != 25) begin errors++; $display("FAIL uneven_cycles got %0d want 25", cyc); end
        checks++;
        if (ld_log.size() != 4) begin errors++; $display("FAIL uneven_ld_count got %0d want 4", ld_log.size()); end
        for (int i = 0; i < 4 && i < ld_log.size(); i++) begin
            checks++;
            if (ld_log[i] != exp_ld[i]) begin
                errors++;
                $display("FAIL uneven_ld%0d got %h want %h", i, ld_log[i], exp_ld[i]);
            end
        end
        checks++;
        if (wr_log.size() != 5) begin errors++; $display("FAIL uneven_wr_count got %0d want 5", wr_log.size()); end
        for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i] != exp_wr[i]) begin
                errors++;
                $display("FAIL uneven_wr%0d got %h want %h", i, wr_log[i], exp_wr[i]);
            end
        end
        checks++;
        if (n_arr_start != 2) begin errors++; $display("FAIL uneven_arr_start got %0d want 2", n_arr_start); end
    endtask

    // m=n=8,k=3: tile order (0,0),(0,1),(1,0),(1,1); 15 cycles per tile.
    task automatic test_multi_tile();
        int cyc;
        bit to;
        int abase[4] = '{0, 0, 3, 3};
        int bbase[4] = '{0, 3, 0, 3};
        int obase[4] = '{0, 8, 4, 12};
        int e;
        run_gemm(8, 8, 3, -1, -1, cyc, to);
        checks++;
        if (to || cyc != 60) begin errors++; $display("FAIL multi_cycles got %0d want 60", cyc); end
        checks++;
        if (ld_log.size() != 12 || wr_log.size() != 16) begin
            errors++;
            $display("FAIL multi_counts got ld=%0d wr=%0d want ld=12 wr=16", ld_log.size(), wr_log.size());
        end
        for (int t = 0; t < 4; t++) begin
            for (int kk = 0; kk < 3 && t*3+kk < ld_log.size(); kk++) begin
                e = ((abase[t] + kk) << 16) | ((bbase[t] + kk) << 8) | kk;
                checks++;
                if (ld_log[t*3+kk] != e) begin
                    errors++;
                    $display("FAIL multi_ld_t%0d_k%0d got %h want %h", t, kk, ld_log[t*3+kk], e);
                end
            end
            for (int r = 0; r < 4 && t*4+r < wr_log.size(); r++) begin
                e = ((obase[t] + r) << 8) | (r << 4) | 15;
                checks++;
                if (wr_log[t*4+r] != e) begin
                    errors++;
                    $display("FAIL multi_wr_t%0d_r%0d got %h want %h", t, r, wr_log[t*4+r], e);
                end
            end
        end
        checks++;
        if (n_arr_start != 4) begin errors++; $display("FAIL multi_arr_start got %0d want 4", n_arr_start); end
`ifdef TPU_SCHED_PERF_EN
        checks++;
        if (perf_cycles !== 16'd60) begin errors++; $display("FAIL multi_perf got %0d want 60", perf_cycles); end
`endif
    endtask

    task automatic test_zero_dim();
        int cyc;
        bit to;
        run_gemm(4, 4, 0, -1, -1, cyc, to);
        checks++;
        if (to || cyc != 0) begin errors++; $display("FAIL zero_k_latency got %0d want 0", cyc); end
        checks++;
        if (ld_log.size() + wr_log.size() + n_arr_start != 0) begin
            errors++;
            $display("FAIL zero_k_activity got ld=%0d wr=%0d st=%0d want 0", ld_log.size(), wr_log.size(), n_arr_start);
        end
        run_gemm(0, 3, 3, -1, -1, cyc, to);
        repeat (3) @(negedge clk);
        checks++;
        if (to || cyc != 0 || ld_log.size() + wr_log.size() + n_arr_start != 0) begin
            errors++;
            $display("FAIL zero_m got cyc=%0d ld=%0d wr=%0d want 0", cyc, ld_log.size(), wr_log.size());
        end
    endtask

    // Abort in COMPUTE, confirm silence, then a clean run.
    task automatic test_reset_mid();
        logic [40:0] outs;
        @(negedge clk);
        bus.m = 4'd4; bus.n = 4'd4; bus.k = 4'd4;
        bus.start = 1'b1;
        wr_log.delete();
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (n_arr_start < 1) begin errors++; $display("FAIL rstmid_in_compute got arr_start=0 want >=1"); end
        rst = 1'b1;
        @(negedge clk);
        outs = {bus.done, bus.ld_en, bus.arr_start, bus.wr_en_out, bus.index_a, bus.index_b,
                bus.ld_k, bus.res_sel, bus.col_mask, bus.index_out};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL rstmid_outputs got %h want 0", outs); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (wr_log.size() != 0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet got wr=%0d done=%b want 0 0", wr_log.size(), bus.done);
        end
        test_single_tile("after_rst", -1, -1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.m = '0;
        bus.n = '0;
        bus.k = '0;
        test_reset();
        test_single_tile("basic", -1, -1);
        test_uneven();
        test_multi_tile();
        test_zero_dim();
        test_single_tile("ignored", 1, 7);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
